// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if
// Bundles the requester handshake and the APB bus around apb_req_arbiter.
//   req, req_write         per-requester request and direction (1 = write)
//   req_addr, req_wdata    flattened per-requester address/data, requester i at [32i+31:32i]
//   gnt, done, err, rdata  grant, one-cycle completion pulse, error qualifier, read data
//   paddr, pwdata, pwrite, penable, pselx   APB outputs
//   prdata, pready         APB slave response
// Modports: master = arbiter side, slave = requesters plus APB slave side.
interface apb_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [31:0]        rdata;
  logic [31:0]        prdata;
  logic               pready;
  logic [31:0]        paddr;
  logic [31:0]        pwdata;
  logic               pwrite;
  logic               penable;
  logic [2:0]         pselx;

  modport master (
    input  req, req_write, req_addr, req_wdata, prdata, pready,
    output gnt, done, err, rdata, paddr, pwdata, pwrite, penable, pselx
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata, pready,
    input  gnt, done, err, rdata, paddr, pwdata, pwrite, penable, pselx
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Round-robin arbiter and APB master sequencer sharing one APB bus between
// NREQ requesters. Targets are decoded into a one-hot pselx; unmapped
// addresses finish with err and never reach the bus.
// Ports:
//   hclk      clock
//   hresetn   asynchronous active-low reset
//   bus       apb_req_arbiter_if.master (requester handshake + APB bus)
// Parameters: NREQ (2..8) requesters, TIMEOUT ACCESS wait limit.
// Optional build macro APB_ARB_TIMEOUT_EN: abort an ACCESS phase that waits
// TIMEOUT cycles for pready and report it with err. Without it ACCESS waits
// indefinitely and TIMEOUT has no effect.
//
// state  | meaning
// IDLE   | bus free; arbitrate; also the done cycle of a completed APB transfer
// SETUP  | APB setup phase, pselx driven, penable low
// ACCESS | APB access phase, penable high, waiting for pready
// ERR    | one-cycle decode-error completion, nothing on APB
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input logic            hclk,
  input logic            hresetn,
  apb_req_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("apb_req_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] win_oh;
  logic [31:0]     win_addr;
  logic [31:0]     win_wdata;
  logic            win_write;
  logic [2:0]      win_sel;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
`endif

  // Only the top six address bits matter: each region is 64 MiB.
  function automatic logic [2:0] decode(input logic [5:0] top6);
    case (top6)
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  // Search starts just after the previous winner, so the previous winner
  // is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_oh    = NREQ'(1) << winner;
  assign win_addr  = bus.req_addr[{winner, 5'b0} +: 32];
  assign win_wdata = bus.req_wdata[{winner, 5'b0} +: 32];
  assign win_write = bus.req_write[winner];
  assign win_sel   = decode(win_addr[31:26]);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= IDLE;
      last        <= IW'(NREQ - 1);
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.err     <= 1'b0;
      bus.rdata   <= '0;
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
      bus.pwrite  <= 1'b0;
      bus.penable <= 1'b0;
      bus.pselx   <= 3'b000;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= '0;
          bus.err  <= 1'b0;
          bus.gnt  <= '0;
          if (found) begin
            bus.gnt    <= win_oh;
            last       <= winner;
            bus.paddr  <= win_addr;
            bus.pwdata <= win_wdata;
            bus.pwrite <= win_write;
            if (win_sel != 3'b000) begin
              bus.pselx <= win_sel;
              state     <= SETUP;
            end else begin
              // Decode error is reported straight away from ERR.
              bus.done  <= win_oh;
              bus.err   <= 1'b1;
              bus.rdata <= '0;
              state     <= ERR;
            end
          end
        end

        SETUP: begin
          bus.penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt     <= '0;
`endif
          state       <= ACCESS;
        end

        ACCESS: begin
          if (bus.pready) begin
            bus.rdata   <= bus.pwrite ? 32'h0 : bus.prdata;
            bus.done    <= bus.gnt;
            bus.err     <= 1'b0;
            bus.gnt     <= '0;
            bus.pselx   <= 3'b000;
            bus.penable <= 1'b0;
            state       <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // tmo_cnt counts completed wait cycles; this is the TIMEOUT-th one.
          else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            bus.rdata   <= '0;
            bus.done    <= bus.gnt;
            bus.err     <= 1'b1;
            bus.gnt     <= '0;
            bus.pselx   <= 3'b000;
            bus.penable <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ERR: begin
          bus.done <= '0;
          bus.err  <= 1'b0;
          bus.gnt  <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter. A transaction-level model predicts every
// output each cycle and a compare process checks the DUT on the falling edge;
// directed tests add literal expectations for latencies, grant order and
// reset behaviour. Timeout tests run only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic hclk    = 1'b0;
  logic hresetn = 1'b0;

  apb_req_arbiter_if #(.NREQ(NREQ)) bus_if ();

  apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus_if)
  );

  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int              m_last;
  int              m_owner;
  int              m_age;
  bit              m_mapped;
  bit              m_rchk;
  logic [NREQ-1:0] e_gnt, e_done;
  logic            e_err, e_pwrite, e_penable;
  logic [31:0]     e_rdata, e_paddr, e_pwdata;
  logic [2:0]      e_pselx;

  function automatic logic [2:0] region(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_last   = NREQ - 1;
    m_owner  = -1;
    m_age    = 0;
    m_mapped = 1'b0;
    m_rchk   = 1'b0;
    e_gnt = '0; e_done = '0; e_err = 1'b0; e_rdata = '0;
    e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_penable = 1'b0; e_pselx = 3'b000;
  endtask

  task automatic finish_xfer(input bit is_err);
    e_done    = e_gnt;
    e_err     = is_err;
    m_rchk    = is_err || !e_pwrite;
    if (is_err) e_rdata = '0;
    else if (!e_pwrite) e_rdata = bus_if.prdata;
    e_gnt     = '0;
    e_pselx   = 3'b000;
    e_penable = 1'b0;
    m_owner   = -1;
  endtask

  // Age = cycles since the grant edge: age 0 ends the setup cycle, age n>0
  // ends the n-th access cycle.
  task automatic model_step();
    bit found;
    e_done = '0;
    e_err  = 1'b0;
    found  = 1'b0;
    if (m_owner < 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int c;
        c = (m_last + i) % NREQ;
        if (!found && bus_if.req[c]) begin
          found    = 1'b1;
          m_last   = c;
          m_owner  = c;
          m_age    = 0;
          e_gnt    = NREQ'(1) << c;
          e_paddr  = bus_if.req_addr[32*c +: 32];
          e_pwdata = bus_if.req_wdata[32*c +: 32];
          e_pwrite = bus_if.req_write[c];
          m_mapped = region(e_paddr) != 3'b000;
          if (m_mapped) begin
            e_pselx   = region(e_paddr);
            e_penable = 1'b0;
          end else begin
            e_done  = e_gnt;
            e_err   = 1'b1;
            e_rdata = '0;
            m_rchk  = 1'b1;
          end
        end
      end
    end else if (!m_mapped) begin
      e_gnt   = '0;
      m_owner = -1;
    end else if (m_age == 0) begin
      e_penable = 1'b1;
      m_age     = 1;
    end else begin
      if (bus_if.pready) finish_xfer(1'b0);
`ifdef APB_ARB_TIMEOUT_EN
      else if (m_age == TMO) finish_xfer(1'b1);
`endif
      else m_age++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge hclk or negedge hresetn);
      if (!hresetn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare ----------------
  initial begin
    forever begin
      @(negedge hclk);
      chk("gnt",     32'(bus_if.gnt),     32'(e_gnt));
      chk("done",    32'(bus_if.done),    32'(e_done));
      chk("err",     32'(bus_if.err),     32'(e_err));
      chk("paddr",   bus_if.paddr,        e_paddr);
      chk("pwdata",  bus_if.pwdata,       e_pwdata);
      chk("pwrite",  32'(bus_if.pwrite),  32'(e_pwrite));
      chk("penable", 32'(bus_if.penable), 32'(e_penable));
      chk("pselx",   32'(bus_if.pselx),   32'(e_pselx));
      if (e_done != '0 && m_rchk) chk("rdata", bus_if.rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  int          pend [NREQ];
  int          ws;
  int          acc_cnt;
  logic [31:0] slv_rdata;

  // One clock: APB slave response (ws wait states, ws < 0 = never ready) and
  // requesters dropping req in their done cycle once no transfers remain.
  task automatic tick();
    @(posedge hclk);
    #1;
    if (bus_if.penable && bus_if.pselx != 3'b000) begin
      bus_if.pready = (ws >= 0 && acc_cnt == ws);
      acc_cnt++;
    end else begin
      bus_if.pready = 1'b0;
      acc_cnt = 0;
    end
    bus_if.prdata = slv_rdata;
    for (int i = 0; i < NREQ; i++) begin
      if (bus_if.done[i] && pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) bus_if.req[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n);
    bus_if.req_write[i]          = wr;
    bus_if.req_addr[32*i +: 32]  = addr;
    bus_if.req_wdata[32*i +: 32] = wdata;
    pend[i]                      = n;
    bus_if.req[i]                = 1'b1;
  endtask

  task automatic wait_done(input int i, output int edges, output int acc);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    acc   = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      edges++;
      if (bus_if.penable) acc++;
      if (bus_if.done[i]) seen = 1'b1;
    end
    chk($sformatf("done_seen_req%0d", i), 32'(seen), 32'd1);
  endtask

  int lat, acc, n;
  int order [5];
  int when_ [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus_if.req = '0; bus_if.req_write = '0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
    bus_if.prdata = '0; bus_if.pready = 1'b0;
    ws = 0; acc_cnt = 0; slv_rdata = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;

    repeat (3) tick();
    hresetn = 1'b1;
    tick();
    chk("rst_gnt",   32'(bus_if.gnt),   32'd0);
    chk("rst_done",  32'(bus_if.done),  32'd0);
    chk("rst_pselx", 32'(bus_if.pselx), 32'd0);
    chk("rst_paddr", bus_if.paddr,      32'd0);

    // single zero-wait write
    ws = 0;
    set_req(0, 1'b1, 32'h8000_0010, 32'hA5A5_0001, 1);
    tick();
    chk("wr_setup_pselx",   32'(bus_if.pselx),   32'd1);
    chk("wr_setup_penable", 32'(bus_if.penable), 32'd0);
    chk("wr_gnt",           32'(bus_if.gnt),     32'd1);
    chk("wr_paddr",         bus_if.paddr,        32'h8000_0010);
    chk("wr_pwdata",        bus_if.pwdata,       32'hA5A5_0001);
    chk("wr_pwrite",        32'(bus_if.pwrite),  32'd1);
    tick();
    chk("wr_access_pselx",   32'(bus_if.pselx),   32'd1);
    chk("wr_access_penable", 32'(bus_if.penable), 32'd1);
    tick();
    chk("wr_done",  32'(bus_if.done),  32'd1);
    chk("wr_err",   32'(bus_if.err),   32'd0);
    chk("wr_pselx", 32'(bus_if.pselx), 32'd0);
    repeat (2) tick();

    // read with three wait states
    ws = 3; slv_rdata = 32'h1234_5678;
    set_req(2, 1'b0, 32'h8400_0000, 32'h0000_DEAD, 1);
    wait_done(2, lat, acc);
    chk("rd_latency", 32'(lat), 32'd6);
    chk("rd_access",  32'(acc), 32'd4);
    chk("rd_rdata",   bus_if.rdata, 32'h1234_5678);
    chk("rd_err",     32'(bus_if.err), 32'd0);
    repeat (2) tick();

    // unmapped address
    ws = 0;
    set_req(1, 1'b0, 32'h9000_0000, 32'h0, 1);
    wait_done(1, lat, acc);
    chk("unm_latency", 32'(lat), 32'd1);
    chk("unm_access",  32'(acc), 32'd0);
    chk("unm_err",     32'(bus_if.err), 32'd1);
    chk("unm_pselx",   32'(bus_if.pselx), 32'd0);
    chk("unm_rdata",   bus_if.rdata, 32'd0);
    repeat (2) tick();

    // all four requesters from reset
    hresetn = 1'b0;
    repeat (2) tick();
    hresetn = 1'b1;
    ws = 0; slv_rdata = 32'hCAFE_0000;
    set_req(0, 1'b1, 32'h8000_0100, 32'h0000_1000, 2);
    set_req(1, 1'b0, 32'h8400_0104, 32'h0000_1001, 1);
    set_req(2, 1'b1, 32'h8800_0108, 32'h0000_1002, 1);
    set_req(3, 1'b0, 32'h8000_010C, 32'h0000_1003, 1);
    n = 0;
    for (int cyc = 1; cyc <= 40 && n < 5; cyc++) begin
      tick();
      if (bus_if.done != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus_if.done[i]) order[n] = i;
        when_[n] = cyc;
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'd5);
    for (int k = 0; k < 5 && k < n; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(when_[k] - when_[k-1]), 32'd3);
    end
    chk("rr_first_done", 32'(when_[0]), 32'd3);
    repeat (2) tick();

    // asynchronous reset during ACCESS
    ws = -1;
    set_req(1, 1'b0, 32'h8800_0000, 32'h0, 1);
    for (int k = 0; k < 10 && !bus_if.penable; k++) tick();
    chk("mid_reached_access", 32'(bus_if.penable), 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("mid_pselx",   32'(bus_if.pselx),   32'd0);
    chk("mid_penable", 32'(bus_if.penable), 32'd0);
    chk("mid_done",    32'(bus_if.done),    32'd0);
    chk("mid_gnt",     32'(bus_if.gnt),     32'd0);
    bus_if.req = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    ws = 0;
    repeat (2) tick();
    hresetn = 1'b1;
    set_req(3, 1'b1, 32'h8000_0000, 32'h0000_3333, 1);
    set_req(0, 1'b1, 32'h8000_0004, 32'h0000_1111, 1);
    tick();
    chk("post_rst_gnt", 32'(bus_if.gnt), 32'd1);
    wait_done(0, lat, acc);
    chk("post_rst_lat0", 32'(lat), 32'd2);
    wait_done(3, lat, acc);
    chk("post_rst_lat3", 32'(lat), 32'd3);
    chk("post_rst_err",  32'(bus_if.err), 32'd0);
    repeat (2) tick();

`ifdef APB_ARB_TIMEOUT_EN
    ws = -1;
    set_req(0, 1'b0, 32'h8000_0020, 32'h0, 1);
    wait_done(0, lat, acc);
    chk("tmo_latency", 32'(lat), 32'd18);
    chk("tmo_access",  32'(acc), 32'd16);
    chk("tmo_err",     32'(bus_if.err), 32'd1);
    chk("tmo_rdata",   bus_if.rdata, 32'd0);
    repeat (2) tick();
    ws = 0; slv_rdata = 32'h0BAD_F00D;
    set_req(3, 1'b0, 32'h8400_0030, 32'h0, 1);
    wait_done(3, lat, acc);
    chk("tmo_next_latency", 32'(lat), 32'd3);
    chk("tmo_next_err",     32'(bus_if.err), 32'd0);
    chk("tmo_next_rdata",   bus_if.rdata, 32'h0BAD_F00D);
    repeat (2) tick();
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
